// File: rtl/pcie_cfg_pkg.sv
// Shared constants, field positions and FSM encoding for the PCIe config/MSI bridge
// between the hard-IP wrapper and the RIFFA core.
package pcie_cfg_pkg;

    localparam logic [3:0] CFG_ADDR_DEVCTRL = 4'h0;
    localparam logic [3:0] CFG_ADDR_CMD     = 4'h3;
    localparam logic [3:0] CFG_ADDR_MSI     = 4'hD;
    localparam logic [3:0] CFG_ADDR_BUSDEV  = 4'hF;

    // Field positions inside the captured tl_cfg_ctl word
    localparam int DEVCTRL_LSB     = 16;
    localparam int DEVCTRL_MPS_LSB = 5;
    localparam int DEVCTRL_MRR_LSB = 12;
    localparam int CMD_BME_BIT     = 2;
    localparam int MSI_EN_BIT      = 0;
    localparam int MSI_MME_LSB     = 4;
    localparam int BUSDEV_BUS_LSB  = 5;
    localparam int BUSDEV_DEV_LSB  = 0;

    localparam int SEEN_DEVCTRL = 0;
    localparam int SEEN_CMD     = 1;
    localparam int SEEN_MSI     = 2;
    localparam int SEEN_BUSDEV  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } msi_state_t;

    function automatic logic [15:0] completer_id(input logic [12:0] busdev);
        return {busdev[BUSDEV_BUS_LSB +: 8], busdev[BUSDEV_DEV_LSB +: 5], 3'b000};
    endfunction

endpackage

// File: rtl/pcie_cfg_msi_ctrl_if.sv
// Hard-IP facing bus: time-multiplexed config port plus the MSI request/ack pair.
interface pcie_cfg_msi_ctrl_if;
    logic [3:0]  tl_cfg_add;
    logic [31:0] tl_cfg_ctl;
    logic        app_msi_req;
    logic        app_msi_ack;
    logic [4:0]  app_msi_num;
    logic [2:0]  app_msi_tc;

    modport master (
        output tl_cfg_add, tl_cfg_ctl, app_msi_ack,
        input  app_msi_req, app_msi_num, app_msi_tc
    );

    modport slave (
        input  tl_cfg_add, tl_cfg_ctl, app_msi_ack,
        output app_msi_req, app_msi_num, app_msi_tc
    );
endinterface

// File: rtl/pcie_cfg_sampler.sv
// Waits for tl_cfg_add to hold steady for SETTLE_CYCLES, then latches the
// addressed tl_cfg_ctl field into stable config registers.
module pcie_cfg_sampler
    import pcie_cfg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  tl_cfg_add,
    input  logic [31:0] tl_cfg_ctl,
    output logic        cfg_bus_mstr_enable,
    output logic [2:0]  cfg_max_payload,
    output logic [2:0]  cfg_max_read_req,
    output logic [15:0] cfg_completer_id,
    output logic        cfg_msi_enable,
    output logic [2:0]  cfg_msi_mme,
    output logic        cfg_valid
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);

    logic [3:0] add_q_r;
    logic [3:0] settle_cnt_r;
    logic [3:0] seen_r;
    logic [3:0] seen_next_s;
    logic       stable_s;
    logic       capture_s;
    logic       unused_ctl_s;

    // Only a handful of ctl bits matter; fold the rest so none read as dangling.
    assign unused_ctl_s = ^tl_cfg_ctl;

    // Stability detect, capture strobe and next seen-mask
    always_comb begin
        stable_s    = (tl_cfg_add == add_q_r);
        capture_s   = stable_s && (settle_cnt_r == (SETTLE_MAX - 4'd1));
        seen_next_s = seen_r;
        if (capture_s) begin
            case (tl_cfg_add)
                CFG_ADDR_DEVCTRL: seen_next_s[SEEN_DEVCTRL] = 1'b1;
                CFG_ADDR_CMD:     seen_next_s[SEEN_CMD]     = 1'b1;
                CFG_ADDR_MSI:     seen_next_s[SEEN_MSI]     = 1'b1;
                CFG_ADDR_BUSDEV:  seen_next_s[SEEN_BUSDEV]  = 1'b1;
                default:          seen_next_s = seen_r;
            endcase
        end else begin
            seen_next_s = seen_r;
        end
    end

    // Address history and saturating settle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_q_r      <= 4'h0;
            settle_cnt_r <= 4'd0;
        end else begin
            add_q_r <= tl_cfg_add;
            if (!stable_s) begin
                settle_cnt_r <= 4'd0;
            end else if (settle_cnt_r != SETTLE_MAX) begin
                settle_cnt_r <= settle_cnt_r + 4'd1;
            end
        end
    end

    // Field capture on the single settle strobe; later captures overwrite
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_bus_mstr_enable <= 1'b0;
            cfg_max_payload     <= 3'd0;
            cfg_max_read_req    <= 3'd0;
            cfg_completer_id    <= 16'h0000;
            cfg_msi_enable      <= 1'b0;
            cfg_msi_mme         <= 3'd0;
            seen_r              <= 4'h0;
            cfg_valid           <= 1'b0;
        end else begin
            seen_r    <= seen_next_s;
            cfg_valid <= &seen_next_s;
            if (capture_s) begin
                case (tl_cfg_add)
                    CFG_ADDR_DEVCTRL: begin
                        cfg_max_payload  <= tl_cfg_ctl[DEVCTRL_LSB + DEVCTRL_MPS_LSB +: 3];
                        cfg_max_read_req <= tl_cfg_ctl[DEVCTRL_LSB + DEVCTRL_MRR_LSB +: 3];
                    end
                    CFG_ADDR_CMD:    cfg_bus_mstr_enable <= tl_cfg_ctl[CMD_BME_BIT];
                    CFG_ADDR_MSI: begin
                        cfg_msi_enable <= tl_cfg_ctl[MSI_EN_BIT];
                        cfg_msi_mme    <= tl_cfg_ctl[MSI_MME_LSB +: 3];
                    end
                    CFG_ADDR_BUSDEV: cfg_completer_id <= completer_id(tl_cfg_ctl[12:0]);
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pcie_cfg_msi_ctrl.sv
// Config-bus demux plus level-interrupt to app_msi_req/ack converter for RIFFA
// on the Cyclone 10 / Arria 10 PCIe hard IP.
module pcie_cfg_msi_ctrl
    import pcie_cfg_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 3,
    parameter int         MSI_TIMEOUT   = 1023,
    parameter logic [4:0] MSI_NUM       = 5'd0
) (
    input  logic                      pld_clk,
    input  logic                      pld_rst_n,
    pcie_cfg_msi_ctrl_if.slave        hip,
    input  logic                      intr,
    output logic                      intr_ready,
    output logic                      intr_err,
    output logic                      cfg_bus_mstr_enable,
    output logic [2:0]                cfg_max_payload,
    output logic [2:0]                cfg_max_read_req,
    output logic [15:0]               cfg_completer_id,
    output logic                      cfg_msi_enable,
    output logic [2:0]                cfg_msi_mme,
    output logic                      cfg_valid
);

    localparam int TW = (MSI_TIMEOUT < 2) ? 1 : $clog2(MSI_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MSI_TIMEOUT - 1);

    msi_state_t    state_r, state_next_s;
    logic [TW-1:0] tcnt_r, tcnt_next_s;
    logic          req_r, req_next_s;
    logic          ready_r, ready_next_s;
    logic          err_r, err_next_s;
    logic [4:0]    msi_num_r;
    logic [2:0]    msi_tc_r;

    pcie_cfg_sampler #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_sampler (
        .clk                 (pld_clk),
        .rst_n               (pld_rst_n),
        .tl_cfg_add          (hip.tl_cfg_add),
        .tl_cfg_ctl          (hip.tl_cfg_ctl),
        .cfg_bus_mstr_enable (cfg_bus_mstr_enable),
        .cfg_max_payload     (cfg_max_payload),
        .cfg_max_read_req    (cfg_max_read_req),
        .cfg_completer_id    (cfg_completer_id),
        .cfg_msi_enable      (cfg_msi_enable),
        .cfg_msi_mme         (cfg_msi_mme),
        .cfg_valid           (cfg_valid)
    );

    assign hip.app_msi_req = req_r;
    assign hip.app_msi_num = msi_num_r;
    assign hip.app_msi_tc  = msi_tc_r;
    assign intr_ready      = ready_r;
    assign intr_err        = err_r;

    // MSI next-state and next-output decode
    always_comb begin
        state_next_s = state_r;
        tcnt_next_s  = tcnt_r;
        req_next_s   = 1'b0;
        ready_next_s = 1'b0;
        err_next_s   = err_r;
        case (state_r)
            IDLE: begin
                if (intr && cfg_msi_enable && cfg_bus_mstr_enable) begin
                    state_next_s = REQ;
                    req_next_s   = 1'b1;
                    tcnt_next_s  = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                // Ack wins; losing MSI enable abandons quietly; timeout flags an error.
                if (hip.app_msi_ack) begin
                    state_next_s = HOLD;
                    ready_next_s = 1'b1;
                end else if (!cfg_msi_enable) begin
                    state_next_s = HOLD;
                end else if (tcnt_r == TIMEOUT_LAST) begin
                    state_next_s = HOLD;
                    err_next_s   = 1'b1;
                end else begin
                    req_next_s   = 1'b1;
                    tcnt_next_s  = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            HOLD: begin
                if (!intr) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // MSI state and registered handshake outputs
    always_ff @(posedge pld_clk) begin
        if (!pld_rst_n) begin
            state_r   <= IDLE;
            tcnt_r    <= '0;
            req_r     <= 1'b0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            msi_num_r <= MSI_NUM;
            msi_tc_r  <= 3'd0;
        end else begin
            state_r   <= state_next_s;
            tcnt_r    <= tcnt_next_s;
            req_r     <= req_next_s;
            ready_r   <= ready_next_s;
            err_r     <= err_next_s;
            msi_num_r <= MSI_NUM;
            msi_tc_r  <= 3'd0;
        end
    end

endmodule

// File: tb/tb_pcie_cfg_msi_ctrl.sv
// Bench for pcie_cfg_msi_ctrl: table vectors for config capture, hand sequences
// for the MSI handshake, and random config traffic against a history-based model.
module tb_pcie_cfg_msi_ctrl;

    localparam int         SETTLE  = 3;
    localparam int         TIMEOUT = 16;
    localparam logic [4:0] NUM     = 5'd7;

    logic        pld_clk = 1'b0;
    logic        pld_rst_n;
    logic        intr;
    logic        intr_ready, intr_err;
    logic        cfg_bus_mstr_enable, cfg_msi_enable, cfg_valid;
    logic [2:0]  cfg_max_payload, cfg_max_read_req, cfg_msi_mme;
    logic [15:0] cfg_completer_id;

    pcie_cfg_msi_ctrl_if bus ();

    pcie_cfg_msi_ctrl #(.SETTLE_CYCLES(SETTLE), .MSI_TIMEOUT(TIMEOUT), .MSI_NUM(NUM)) dut (
        .pld_clk             (pld_clk),
        .pld_rst_n           (pld_rst_n),
        .hip                 (bus),
        .intr                (intr),
        .intr_ready          (intr_ready),
        .intr_err            (intr_err),
        .cfg_bus_mstr_enable (cfg_bus_mstr_enable),
        .cfg_max_payload     (cfg_max_payload),
        .cfg_max_read_req    (cfg_max_read_req),
        .cfg_completer_id    (cfg_completer_id),
        .cfg_msi_enable      (cfg_msi_enable),
        .cfg_msi_mme         (cfg_msi_mme),
        .cfg_valid           (cfg_valid)
    );

    always #5 pld_clk = ~pld_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: raw captured words plus the address history
    logic [3:0]  hist[$];
    logic [15:0] m_dev, m_cmd, m_msi;
    logic [12:0] m_bd;
    logic [3:0]  m_seen;

    typedef struct {
        logic [3:0]  add;
        logic [31:0] ctl;
        int          hold;
        logic [27:0] exp;
    } vec_t;

    function automatic logic [27:0] pack(input logic bme, input logic [2:0] mps, input logic [2:0] mrr,
                                         input logic [15:0] cid, input logic en, input logic [2:0] mme,
                                         input logic valid);
        return {bme, mps, mrr, cid, en, mme, valid};
    endfunction

    function automatic logic [27:0] dut_cfg();
        return pack(cfg_bus_mstr_enable, cfg_max_payload, cfg_max_read_req, cfg_completer_id,
                    cfg_msi_enable, cfg_msi_mme, cfg_valid);
    endfunction

    function automatic logic [27:0] model_cfg();
        return pack(m_cmd[2], m_dev[7:5], m_dev[14:12], {m_bd[12:5], m_bd[4:0], 3'b000},
                    m_msi[0], m_msi[6:4], &m_seen);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model consumes the inputs present at the edge, then cfg outputs are compared.
    task automatic tick();
        logic [3:0]  a;
        logic [31:0] c;
        logic        rn;
        int          run;
        a  = bus.tl_cfg_add;
        c  = bus.tl_cfg_ctl;
        rn = pld_rst_n;
        @(posedge pld_clk);
        #1;
        if (!rn) begin
            hist.delete();
            hist.push_back(4'h0);
            m_dev = 16'h0; m_cmd = 16'h0; m_msi = 16'h0; m_bd = 13'h0; m_seen = 4'h0;
        end else begin
            hist.push_back(a);
            if (hist.size() > 24) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i > 0; i--) begin
                if (hist[i] != hist[i-1]) break;
                run++;
            end
            if (run == SETTLE) begin
                case (a)
                    4'h0: begin m_dev = c[31:16]; m_seen[0] = 1'b1; end
                    4'h3: begin m_cmd = c[15:0];  m_seen[1] = 1'b1; end
                    4'hD: begin m_msi = c[15:0];  m_seen[2] = 1'b1; end
                    4'hF: begin m_bd  = c[12:0];  m_seen[3] = 1'b1; end
                    default: ;
                endcase
            end
        end
        check("cfg_model", {4'h0, dut_cfg()}, {4'h0, model_cfg()});
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] c);
        bus.tl_cfg_add = a;
        bus.tl_cfg_ctl = c;
        repeat (8) tick();
        bus.tl_cfg_add = 4'h1;
        repeat (8) tick();
    endtask

    vec_t vecs[6];

    initial begin
        int   high;
        int   drop_at;
        logic bad;

        vecs[0] = '{4'h0, 32'h20A0_0000, 8, pack(1'b0, 3'd5, 3'd2, 16'h0000, 1'b0, 3'd0, 1'b0)};
        vecs[1] = '{4'h3, 32'h0000_0006, 8, pack(1'b1, 3'd5, 3'd2, 16'h0000, 1'b0, 3'd0, 1'b0)};
        vecs[2] = '{4'hD, 32'h0000_0031, 8, pack(1'b1, 3'd5, 3'd2, 16'h0000, 1'b1, 3'd3, 1'b0)};
        vecs[3] = '{4'hF, 32'h0000_0A43, 8, pack(1'b1, 3'd5, 3'd2, 16'h5218, 1'b1, 3'd3, 1'b1)};
        vecs[4] = '{4'hD, 32'h0000_0000, 2, pack(1'b1, 3'd5, 3'd2, 16'h5218, 1'b1, 3'd3, 1'b1)};
        vecs[5] = '{4'h5, 32'hFFFF_FFFF, 8, pack(1'b1, 3'd5, 3'd2, 16'h5218, 1'b1, 3'd3, 1'b1)};

        pld_rst_n       = 1'b0;
        intr            = 1'b0;
        bus.tl_cfg_add  = 4'h1;
        bus.tl_cfg_ctl  = 32'h0;
        bus.app_msi_ack = 1'b0;
        repeat (3) tick();
        pld_rst_n = 1'b1;
        check("rst_num", {27'h0, bus.app_msi_num}, {27'h0, NUM});
        check("rst_outs", {28'h0, bus.app_msi_tc, bus.app_msi_req}, 32'h0);
        check("rst_irq", {30'h0, intr_ready, intr_err}, 32'h0);

        // Table-driven config capture, including a too-short hold and an ignored address
        for (int e = 0; e < 6; e++) begin
            bus.tl_cfg_add = vecs[e].add;
            bus.tl_cfg_ctl = vecs[e].ctl;
            repeat (vecs[e].hold) tick();
            check($sformatf("vec%0d", e), {4'h0, dut_cfg()}, {4'h0, vecs[e].exp});
        end

        // Acked MSI: ack arrives while req has been high for 5 samples
        intr = 1'b1;
        tick();
        check("ack_req_start", {31'h0, bus.app_msi_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ack_req_held", {30'h0, bus.app_msi_req, intr_ready}, 32'd2);
        end
        bus.app_msi_ack = 1'b1;
        tick();
        check("ack_done", {30'h0, bus.app_msi_req, intr_ready}, 32'd1);
        bus.app_msi_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_quiet", {30'h0, bus.app_msi_req, intr_ready}, 32'd0);
        end
        intr = 1'b0;
        tick();
        intr = 1'b1;
        tick();
        check("rearm_req", {31'h0, bus.app_msi_req}, 32'd1);

        // MSI disabled mid-request: abandon without error
        bus.tl_cfg_add = 4'hD;
        bus.tl_cfg_ctl = 32'h0;
        drop_at = 0;
        bad     = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (intr_ready) bad = 1'b1;
            if (!bus.app_msi_req && drop_at == 0) drop_at = i;
        end
        check("abort_cycle", drop_at, 5);
        check("abort_flags", {30'h0, bad, intr_err}, 32'd0);
        bus.tl_cfg_add = 4'h1;
        intr = 1'b0;
        repeat (2) tick();

        // Interrupt with MSI disabled produces nothing
        intr = 1'b1;
        bad  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.app_msi_req || intr_ready) bad = 1'b1;
        end
        check("disabled_quiet", {31'h0, bad}, 32'd0);
        intr = 1'b0;
        tick();

        // Timeout: req held exactly TIMEOUT cycles, sticky error, no ready
        cfg_write(4'hD, 32'h0000_0031);
        intr = 1'b1;
        tick();
        high = bus.app_msi_req ? 1 : 0;
        bad  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (intr_ready) bad = 1'b1;
            if (!bus.app_msi_req) break;
            high++;
        end
        check("timeout_len", high, TIMEOUT);
        check("timeout_err", {30'h0, bad, intr_err}, 32'd1);
        intr = 1'b0;
        tick();

        // Ack while idle is ignored
        bus.app_msi_ack = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (bus.app_msi_req || intr_ready) bad = 1'b1;
        end
        check("idle_ack", {31'h0, bad}, 32'd0);
        bus.app_msi_ack = 1'b0;

        // Random config traffic against the model
        for (int s = 0; s < 200; s++) begin
            case ($urandom_range(0, 4))
                0: bus.tl_cfg_add = 4'h0;
                1: bus.tl_cfg_add = 4'h3;
                2: bus.tl_cfg_add = 4'hD;
                3: bus.tl_cfg_add = 4'hF;
                default: bus.tl_cfg_add = 4'($urandom_range(0, 15));
            endcase
            bus.tl_cfg_ctl = $urandom;
            repeat ($urandom_range(1, 6)) tick();
        end

        // Reset in REQ, then a stray ack
        cfg_write(4'hD, 32'h0000_0001);
        cfg_write(4'h3, 32'h0000_0004);
        intr = 1'b1;
        tick();
        check("pre_rst_req", {31'h0, bus.app_msi_req}, 32'd1);
        pld_rst_n = 1'b0;
        tick();
        check("rst_mid_req", {28'h0, bus.app_msi_tc, bus.app_msi_req}, 32'd0);
        check("rst_mid_irq", {30'h0, intr_ready, intr_err}, 32'd0);
        check("rst_mid_cfg", {4'h0, dut_cfg()}, 32'd0);
        check("rst_mid_num", {27'h0, bus.app_msi_num}, {27'h0, NUM});
        pld_rst_n       = 1'b1;
        intr            = 1'b0;
        bus.app_msi_ack = 1'b1;
        tick();
        check("post_rst_ack", {30'h0, bus.app_msi_req, intr_ready}, 32'd0);
        bus.app_msi_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
